uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ byte requesters into one UART transmitter.
// Optional build macro UART_ARB_TAG_EN prefixes each data byte with a header frame 8'hA0 | grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [7:0]                 o_tx_bin,
  output logic                       o_tx_write,
  input  logic                       i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_err_timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 2);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    DRAIN,
    GAP
`ifdef UART_ARB_TAG_EN
    ,
    TAG_WRITE,
    TAG_DRAIN
`endif
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [7:0]        win_byte;
  logic              tmo_hit;
  logic              gap_done;
  int                idx;
`ifdef UART_ARB_TAG_EN
  logic [7:0]        data_q;
  logic              data_pend;
`endif

  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!win_found && i_req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  assign win_byte = i_req_data[{win_idx, 3'b000} +: 8];
  assign tmo_hit  = (int'(tmo_cnt) >= ACK_TIMEOUT - 1);
  // GAP always lasts at least one cycle, so GAP_CYCLES of 0 behaves like 1.
  assign gap_done = (int'(gap_cnt) >= GAP_CYCLES - 1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_req_ready   <= '0;
      o_tx_write    <= 1'b0;
      o_tx_bin      <= 8'h00;
      o_grant_id    <= '0;
      o_err_timeout <= 1'b0;
      last_grant    <= ID_W'(NUM_REQ - 1);
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
`ifdef UART_ARB_TAG_EN
      data_q        <= 8'h00;
      data_pend     <= 1'b0;
`endif
    end else begin
      o_req_ready   <= '0;
      o_err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found && !i_tx_busy) begin
            o_req_ready <= NUM_REQ'(1) << win_idx;
            o_grant_id  <= win_idx;
            last_grant  <= win_idx;
            tmo_cnt     <= '0;
            o_tx_write  <= 1'b1;
`ifdef UART_ARB_TAG_EN
            o_tx_bin    <= 8'hA0 | 8'(win_idx);
            data_q      <= win_byte;
            data_pend   <= 1'b1;
            state       <= TAG_WRITE;
`else
            o_tx_bin    <= win_byte;
            state       <= WRITE;
`endif
          end
        end
        WRITE: begin
          if (i_tx_busy) begin
            o_tx_write <= 1'b0;
            state      <= DRAIN;
          end else if (tmo_hit) begin
            o_tx_write    <= 1'b0;
            o_err_timeout <= 1'b1;
            state         <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!i_tx_busy) state <= GAP;
        end
`ifdef UART_ARB_TAG_EN
        TAG_WRITE: begin
          if (i_tx_busy) begin
            o_tx_write <= 1'b0;
            state      <= TAG_DRAIN;
          end else if (tmo_hit) begin
            o_tx_write    <= 1'b0;
            o_err_timeout <= 1'b1;
            state         <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        TAG_DRAIN: begin
          if (!i_tx_busy) state <= GAP;
        end
`endif
        GAP: begin
          if (gap_done) begin
            gap_cnt <= '0;
`ifdef UART_ARB_TAG_EN
            if (data_pend) begin
              o_tx_bin   <= data_q;
              o_tx_write <= 1'b1;
              tmo_cnt    <= '0;
              data_pend  <= 1'b0;
              state      <= WRITE;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
